// File: rtl/updown_counter_ctrl_if.sv
// Command handshake bundle for updown_counter_ctrl.
// The master issues op/arg with valid; the slave answers with ready.
interface updown_counter_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/updown_counter_ctrl.sv
// Command-driven up/down counter controller with prescaled ticks,
// bounce / up-wrap / down-wrap modes and single-step support.
module updown_counter_ctrl #(
    parameter int WIDTH = 3,
    parameter int DIV   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_counter_ctrl_if.slave cmd,
    output logic [WIDTH-1:0]     q,
    output logic                 dir_up,
    output logic                 running,
    output logic                 wrap_pulse,
    output logic                 cmd_err
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    localparam logic [2:0] OP_START = 3'd1;
    localparam logic [2:0] OP_STOP  = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_LIMIT = 3'd5;
    localparam logic [2:0] OP_MODE  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [1:0] M_UP   = 2'd1;
    localparam logic [1:0] M_DOWN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_STEP
    } state_e;

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic accept;
    logic active;
    logic tick;
    logic drop;

    assign cmd.cmd_ready = (state_q != S_STEP);
    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign active = (state_q == S_RUN) || (state_q == S_STEP);
    assign tick   = active && (presc_q == PLAST);
    // Data-changing commands and STOP take priority over a same-cycle tick.
    assign drop   = accept && ((cmd.cmd_op == OP_LOAD)
                            || (cmd.cmd_op == OP_LIMIT)
                            || (cmd.cmd_op == OP_MODE)
                            || (cmd.cmd_op == OP_STOP));

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        q_d     = q_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        presc_d = active ? (tick ? '0 : presc_q + 1'b1) : '0;

        if (tick && !drop) begin
            if (lim_q != '0) begin
                case (mode_q)
                    M_UP: begin
                        if (q_q == lim_q) begin
                            q_d    = '0;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = q_q + 1'b1;
                        end
                    end
                    M_DOWN: begin
                        if (q_q == '0) begin
                            q_d    = lim_q;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = q_q - 1'b1;
                        end
                    end
                    default: begin
                        if (dir_q) begin
                            if (q_q == lim_q) begin
                                q_d    = lim_q - 1'b1;
                                dir_d  = 1'b0;
                                wrap_d = 1'b1;
                            end else begin
                                q_d = q_q + 1'b1;
                            end
                        end else begin
                            if (q_q == '0) begin
                                q_d    = WIDTH'(1);
                                dir_d  = 1'b1;
                                wrap_d = 1'b1;
                            end else begin
                                q_d = q_q - 1'b1;
                            end
                        end
                    end
                endcase
            end
            if (state_q == S_STEP) state_d = ret_q;
        end

        if (accept) begin
            case (cmd.cmd_op)
                OP_START: begin
                    if (state_q != S_RUN) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                OP_STOP: begin
                    if (state_q == S_RUN) state_d = S_PAUSE;
                end
                OP_STEP: begin
                    if (state_q != S_RUN) begin
                        state_d = S_STEP;
                        ret_d   = state_q;
                        presc_d = '0;
                    end
                end
                OP_LOAD: begin
                    q_d = (cmd.cmd_arg > lim_q) ? lim_q : cmd.cmd_arg;
                end
                OP_LIMIT: begin
                    lim_d = cmd.cmd_arg;
                    if (q_q > cmd.cmd_arg) q_d = cmd.cmd_arg;
                end
                OP_MODE: begin
                    case (cmd.cmd_arg[1:0])
                        2'd0: mode_d = 2'd0;
                        2'd1: begin
                            mode_d = M_UP;
                            dir_d  = 1'b1;
                        end
                        2'd2: begin
                            mode_d = M_DOWN;
                            dir_d  = 1'b0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                OP_RSVD: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            presc_q <= '0;
            q_q     <= '0;
            lim_q   <= '1;
            mode_q  <= 2'd0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            presc_q <= presc_d;
            q_q     <= q_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign q          = q_q;
    assign dir_up     = dir_q;
    assign running    = (state_q == S_RUN);
    assign wrap_pulse = wrap_q;
    assign cmd_err    = err_q;
endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Drives a DIV=1 and a DIV=4 controller with the same command stream
// and compares both against a behavioural model of the counter.
module tb_updown_counter_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    updown_counter_ctrl_if #(.WIDTH(3)) cmd1 ();
    updown_counter_ctrl_if #(.WIDTH(3)) cmd4 ();

    logic [2:0] q1, q4;
    logic dir1, dir4, run1, run4, wrap1, wrap4, err1, err4;

    updown_counter_ctrl #(.WIDTH(3), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .cmd(cmd1),
        .q(q1), .dir_up(dir1), .running(run1),
        .wrap_pulse(wrap1), .cmd_err(err1)
    );

    updown_counter_ctrl #(.WIDTH(3), .DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .cmd(cmd4),
        .q(q4), .dir_up(dir4), .running(run4),
        .wrap_pulse(wrap4), .cmd_err(err4)
    );

    typedef struct {
        int q;
        int lim;
        int mode;
        bit up;
        bit run;
        bit stp;
        int ph;
        bit wrap;
        bit err;
    } mdl_t;

    mdl_t m1, m4;
    int total = 0;
    int bad = 0;

    task automatic chk(string tag, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m.q = 0; m.lim = 7; m.mode = 0; m.up = 1'b1;
        m.run = 1'b0; m.stp = 1'b0; m.ph = 0;
        m.wrap = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    function automatic mdl_t count(mdl_t m);
        mdl_t n = m;
        if (m.lim == 0) return n;
        if (m.mode == 1) begin
            if (m.q < m.lim) n.q = m.q + 1;
            else begin n.q = 0; n.wrap = 1'b1; end
        end else if (m.mode == 2) begin
            if (m.q > 0) n.q = m.q - 1;
            else begin n.q = m.lim; n.wrap = 1'b1; end
        end else if (m.up) begin
            if (m.q < m.lim) n.q = m.q + 1;
            else begin n.q = m.lim - 1; n.up = 1'b0; n.wrap = 1'b1; end
        end else begin
            if (m.q > 0) n.q = m.q - 1;
            else begin n.q = 1; n.up = 1'b1; n.wrap = 1'b1; end
        end
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int div, bit v, int op, int arg);
        mdl_t n = m;
        bit acc, tick, drop;
        n.wrap = 1'b0;
        n.err = 1'b0;
        acc = v && !m.stp;
        tick = (m.run || m.stp) && (m.ph == div - 1);
        drop = acc && m.run && (op == 2 || op == 4 || op == 5 || op == 6);
        if (m.run || m.stp) n.ph = tick ? 0 : m.ph + 1;
        if (tick) begin
            if (!drop) n = count(n);
            if (m.stp) n.stp = 1'b0;
        end
        if (acc) begin
            case (op)
                1: if (!m.run) begin n.run = 1'b1; n.ph = 0; end
                2: n.run = 1'b0;
                3: if (!m.run) begin n.stp = 1'b1; n.ph = 0; end
                4: n.q = (arg > m.lim) ? m.lim : arg;
                5: begin n.lim = arg; if (m.q > arg) n.q = arg; end
                6: begin
                    case (arg % 4)
                        0: n.mode = 0;
                        1: begin n.mode = 1; n.up = 1'b1; end
                        2: begin n.mode = 2; n.up = 1'b0; end
                        default: n.err = 1'b1;
                    endcase
                end
                7: n.err = 1'b1;
                default: ;
            endcase
        end
        if (!n.run && !n.stp) n.ph = 0;
        return n;
    endfunction

    task automatic cmp_all();
        chk("q1", int'(q1), m1.q);
        chk("dir1", int'(dir1), int'(m1.up));
        chk("run1", int'(run1), int'(m1.run));
        chk("wrap1", int'(wrap1), int'(m1.wrap));
        chk("err1", int'(err1), int'(m1.err));
        chk("rdy1", int'(cmd1.cmd_ready), int'(!m1.stp));
        chk("q4", int'(q4), m4.q);
        chk("dir4", int'(dir4), int'(m4.up));
        chk("run4", int'(run4), int'(m4.run));
        chk("wrap4", int'(wrap4), int'(m4.wrap));
        chk("err4", int'(err4), int'(m4.err));
        chk("rdy4", int'(cmd4.cmd_ready), int'(!m4.stp));
    endtask

    task automatic cyc(bit v, int op, int arg);
        mdl_t n1, n4;
        cmd1.cmd_valid = v; cmd1.cmd_op = op[2:0]; cmd1.cmd_arg = arg[2:0];
        cmd4.cmd_valid = v; cmd4.cmd_op = op[2:0]; cmd4.cmd_arg = arg[2:0];
        n1 = mstep(m1, 1, v, op, arg);
        n4 = mstep(m4, 4, v, op, arg);
        @(posedge clk);
        #1;
        m1 = n1;
        m4 = n4;
        cmp_all();
    endtask

    // Reset lands mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        cmd1.cmd_valid = 1'b0;
        cmd4.cmd_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        m1 = mreset();
        m4 = mreset();
        cmp_all();
        @(posedge clk);
        #1 reset = 1'b0;
        cmp_all();
    endtask

    int exp2 [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int exp3 [7]  = '{1, 2, 3, 4, 5, 0, 1};

    initial begin
        cmd1.cmd_valid = 1'b0; cmd1.cmd_op = '0; cmd1.cmd_arg = '0;
        cmd4.cmd_valid = 1'b0; cmd4.cmd_op = '0; cmd4.cmd_arg = '0;
        m1 = mreset();
        m4 = mreset();
        @(posedge clk);
        #1;
        cmp_all();
        reset = 1'b0;

        // reset in the middle of a run at q=5
        cyc(1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("t1_q_before", int'(q1), 5);
        do_reset();
        chk("t1_q", int'(q1), 0);
        chk("t1_run", int'(run1), 0);
        chk("t1_rdy", int'(cmd1.cmd_ready), 1);

        // bounce 0..7..0
        cyc(1, 1, 0);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 0, 0);
            chk("t2_q", int'(q1), exp2[i]);
            chk("t2_wrap", int'(wrap1), int'(i == 7 || i == 14));
        end

        // up-wrap with limit 5
        do_reset();
        cyc(1, 6, 1);
        cyc(1, 5, 5);
        cyc(1, 1, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0);
            chk("t3_q", int'(q1), exp3[i]);
            chk("t3_wrap", int'(wrap1), int'(i == 5));
        end

        // single step on the DIV=4 instance
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        cyc(1, 4, 2);
        cyc(1, 3, 0);
        chk("t4_rdy0", int'(cmd4.cmd_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk("t4_rdy", int'(cmd4.cmd_ready), 0);
        end
        cyc(0, 0, 0);
        chk("t4_rdy1", int'(cmd4.cmd_ready), 1);
        chk("t4_q", int'(q4), 3);
        chk("t4_run", int'(run4), 0);

        // load clamp, limit shrink, illegal mode
        do_reset();
        cyc(1, 5, 4);
        cyc(1, 4, 7);
        chk("t5_load", int'(q1), 4);
        cyc(1, 5, 2);
        chk("t5_lim", int'(q1), 2);
        cyc(1, 6, 3);
        chk("t5_err", int'(err1), 1);
        cyc(1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);

        // load collides with a tick
        do_reset();
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 4, 3);
        chk("t6_q", int'(q1), 3);
        cyc(0, 0, 0);
        chk("t6_q_next", int'(q1), 4);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int op;
            if ($urandom_range(0, 249) == 0) do_reset();
            op = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
